// File: rtl/video_pkg.sv
// Shared video definitions: colour depth default, pixel layout and scan-doubler read states.
package video_pkg;

  localparam int unsigned COLOR_BITS_DEF = 3;
  localparam int unsigned PIX_W          = 3 * COLOR_BITS_DEF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PASS0 = 2'd1,
    PASS1 = 2'd2
  } rd_state_e;

  typedef struct packed {
    logic [COLOR_BITS_DEF-1:0] r;
    logic [COLOR_BITS_DEF-1:0] g;
    logic [COLOR_BITS_DEF-1:0] b;
  } pix_t;

  // Packed {r,g,b} width for an arbitrary colour depth
  function automatic int unsigned pix_w(input int unsigned color_bits);
    return 3 * color_bits;
  endfunction

endpackage

// File: rtl/vga_scandoubler_if.sv
// Native-rate video input and board-pin video output bundle of the scan doubler.
interface vga_scandoubler_if #(
  parameter int unsigned COLOR_BITS = video_pkg::COLOR_BITS_DEF
);

  logic                  vga_en;
  logic                  pix_ce;
  logic [COLOR_BITS-1:0] ri;
  logic [COLOR_BITS-1:0] gi;
  logic [COLOR_BITS-1:0] bi;
  logic                  hsync_in;
  logic                  vsync_in;

  logic [COLOR_BITS-1:0] r;
  logic [COLOR_BITS-1:0] g;
  logic [COLOR_BITS-1:0] b;
  logic                  hsync;
  logic                  vsync;
  logic                  csync;

  // Video source side (machine core / testbench)
  modport master (
    output vga_en, pix_ce, ri, gi, bi, hsync_in, vsync_in,
    input  r, g, b, hsync, vsync, csync
  );

  // Output stage side
  modport slave (
    input  vga_en, pix_ce, ri, gi, bi, hsync_in, vsync_in,
    output r, g, b, hsync, vsync, csync
  );

endinterface

// File: rtl/scandbl_linebuf.sv
// Ping-pong line buffer: simple dual-port RAM, address MSB selects the bank.
module scandbl_linebuf #(
  parameter int unsigned ADDR_W = 9,
  parameter int unsigned PIX_W  = 9
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W:0]   waddr,
  input  logic [PIX_W-1:0]  wdata,
  input  logic [ADDR_W:0]   raddr,
  output logic [PIX_W-1:0]  rdata
);

  localparam int unsigned DEPTH = 2 * (2 ** ADDR_W);

  logic [PIX_W-1:0] mem_q [DEPTH];
  logic [PIX_W-1:0] rdata_q;

  // No reset so the array maps onto block RAM
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
    rdata_q <= mem_q[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/vga_scandoubler.sv
// Video output stage: registered passthrough with composite sync, or 15->31 kHz line doubling
// through ping-pong line buffers.
module vga_scandoubler
  import video_pkg::*;
#(
  parameter int unsigned COLOR_BITS = COLOR_BITS_DEF,
  parameter int unsigned ADDR_W     = 9,
  parameter int unsigned HSYNC_LEN  = 48
) (
  input  logic             clk,
  input  logic             rst,
  vga_scandoubler_if.slave vif
);

  localparam int unsigned PW     = pix_w(COLOR_BITS);
  localparam int unsigned LW     = ADDR_W + 1;
  localparam int unsigned DEPTH  = 2 ** ADDR_W;
  localparam int unsigned HS_MIN = (HSYNC_LEN < DEPTH) ? HSYNC_LEN : DEPTH;

  localparam logic [LW-1:0] WX_SAT = LW'(DEPTH);
  localparam logic [LW-1:0] HS_LIM = LW'(HS_MIN);

  rd_state_e             state_q, state_d;
  logic [ADDR_W-1:0]     rx_q, rx_d;
  logic [LW-1:0]         wx_q, wx_d;
  logic [LW-1:0]         len_q, len_d;
  logic                  wbank_q, wbank_d;
  logic                  rbank_q, rbank_d;
  logic                  vpend_q, vpend_d;
  logic                  mode_q, mode_d;
  logic                  hsin_q, hsin_d;
  logic                  hsin_prev_q, hsin_prev_d;
  logic                  vld_pipe_q, vld_pipe_d;
  logic                  hs_pipe_q, hs_pipe_d;
  logic [COLOR_BITS-1:0] r_q, r_d;
  logic [COLOR_BITS-1:0] g_q, g_d;
  logic [COLOR_BITS-1:0] b_q, b_d;
  logic                  hsync_q, hsync_d;
  logic                  vsync_q, vsync_d;
  logic                  csync_q, csync_d;

  logic                  line_start_c;
  logic                  we_c;
  logic                  pass_last_c;
  logic                  pass0_entry_c;
  logic [PW-1:0]         rd_pix;

  // Rising hsync_in edge, seen one clk late through the registered copy
  assign line_start_c = hsin_q & ~hsin_prev_q;
  assign we_c         = vif.pix_ce & ~vif.hsync_in & (wx_q != WX_SAT);
  assign pass_last_c  = ({1'b0, rx_q} == (len_q - LW'(1)));

  scandbl_linebuf #(
    .ADDR_W (ADDR_W),
    .PIX_W  (PW)
  ) u_linebuf (
    .clk   (clk),
    .we    (we_c),
    .waddr ({wbank_q, wx_q[ADDR_W-1:0]}),
    .wdata ({vif.ri, vif.gi, vif.bi}),
    .raddr ({rbank_q, rx_q}),
    .rdata (rd_pix)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rx_q        <= '0;
      wx_q        <= '0;
      len_q       <= '0;
      wbank_q     <= 1'b0;
      rbank_q     <= 1'b1;
      vpend_q     <= 1'b0;
      mode_q      <= 1'b1;
      hsin_q      <= 1'b0;
      hsin_prev_q <= 1'b0;
      vld_pipe_q  <= 1'b0;
      hs_pipe_q   <= 1'b0;
      r_q         <= '0;
      g_q         <= '0;
      b_q         <= '0;
      hsync_q     <= 1'b0;
      vsync_q     <= 1'b0;
      csync_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      rx_q        <= rx_d;
      wx_q        <= wx_d;
      len_q       <= len_d;
      wbank_q     <= wbank_d;
      rbank_q     <= rbank_d;
      vpend_q     <= vpend_d;
      mode_q      <= mode_d;
      hsin_q      <= hsin_d;
      hsin_prev_q <= hsin_prev_d;
      vld_pipe_q  <= vld_pipe_d;
      hs_pipe_q   <= hs_pipe_d;
      r_q         <= r_d;
      g_q         <= g_d;
      b_q         <= b_d;
      hsync_q     <= hsync_d;
      vsync_q     <= vsync_d;
      csync_q     <= csync_d;
    end
  end

  // Line bookkeeping and read-pass sequencing
  always_comb begin
    state_d       = state_q;
    rx_d          = rx_q;
    wx_d          = wx_q;
    len_d         = len_q;
    wbank_d       = wbank_q;
    rbank_d       = rbank_q;
    vpend_d       = vpend_q;
    pass0_entry_c = 1'b0;
    hsin_d        = vif.hsync_in;
    hsin_prev_d   = hsin_q;
    // Scan-double only once enabled at a line start; dropping vga_en is immediate
    mode_d        = vif.vga_en & (line_start_c | mode_q);

    if (we_c) begin
      wx_d = wx_q + LW'(1);
    end

    unique case (state_q)
      PASS0: begin
        if (pass_last_c) begin
          state_d = PASS1;
          rx_d    = '0;
        end else begin
          rx_d = rx_q + ADDR_W'(1);
        end
      end
      PASS1: begin
        if (pass_last_c) begin
          state_d = IDLE;
          rx_d    = '0;
        end else begin
          rx_d = rx_q + ADDR_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        rx_d    = '0;
      end
    endcase

    // A new line overrides whatever pass is running
    if (line_start_c) begin
      len_d   = wx_q;
      wbank_d = ~wbank_q;
      rbank_d = wbank_q;
      wx_d    = '0;
      vpend_d = vif.vsync_in;
      rx_d    = '0;
      if (mode_d && (wx_q != '0)) begin
        state_d       = PASS0;
        pass0_entry_c = 1'b1;
      end else begin
        state_d = IDLE;
      end
    end

    if (!mode_d) begin
      state_d = IDLE;
      rx_d    = '0;
    end
  end

  // Output pipeline: stage 1 tracks the RAM read, stage 2 is the pin register
  always_comb begin
    vld_pipe_d = (state_q != IDLE);
    hs_pipe_d  = (state_q != IDLE) && ({1'b0, rx_q} < HS_LIM) && ({1'b0, rx_q} < len_q);
    r_d        = '0;
    g_d        = '0;
    b_d        = '0;
    hsync_d    = 1'b0;
    vsync_d    = vsync_q;

    if (mode_d) begin
      hsync_d = hs_pipe_q;
      if (vld_pipe_q && !hs_pipe_q) begin
        r_d = rd_pix[PW-1 -: COLOR_BITS];
        g_d = rd_pix[2*COLOR_BITS-1 -: COLOR_BITS];
        b_d = rd_pix[COLOR_BITS-1:0];
      end
      // vsync follows the line it was sampled on, i.e. one input line late
      if (pass0_entry_c) begin
        vsync_d = vpend_q;
      end
    end else begin
      r_d     = vif.ri;
      g_d     = vif.gi;
      b_d     = vif.bi;
      hsync_d = vif.hsync_in;
      vsync_d = vif.vsync_in;
    end

    csync_d = ~(hsync_d | vsync_d);
  end

  assign vif.r     = r_q;
  assign vif.g     = g_q;
  assign vif.b     = b_q;
  assign vif.hsync = hsync_q;
  assign vif.vsync = vsync_q;
  assign vif.csync = csync_q;

endmodule

// File: tb/tb_vga_scandoubler.sv
// Directed self-checking bench for vga_scandoubler (COLOR_BITS=3, ADDR_W=9, HSYNC_LEN=48).
module tb_vga_scandoubler;

  logic clk = 1'b0;
  logic rst;
  int   n_total = 0;
  int   n_pass  = 0;

  always #5 clk = ~clk;

  vga_scandoubler_if #(.COLOR_BITS(3)) vif ();

  vga_scandoubler #(
    .COLOR_BITS (3),
    .ADDR_W     (9),
    .HSYNC_LEN  (48)
  ) dut (
    .clk (clk),
    .rst (rst),
    .vif (vif)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pixel pattern: kind 0 = n%8 on all channels, 1 = overflow line, 2 = second line of abort test
  function automatic logic [8:0] pix_val(input int kind, input int n);
    logic [2:0] a;
    a = 3'(n % 8);
    case (kind)
      0:       return {a, a, a};
      1:       return (n < 512) ? {a, 3'((n / 8) % 8), 3'(n / 64)} : 9'h1ff;
      default: return {3'(7 - (n % 8)), a, 3'd5};
    endcase
  endfunction

  // Expected {hsync, r, g, b} at output position p of a doubled line of length len
  function automatic logic [9:0] exp_vga(input int p, input int len, input int kind);
    int n;
    if (p < 0 || p >= 2 * len) return 10'd0;
    n = p % len;
    if (n < 48) return {1'b1, 9'd0};
    return {1'b0, pix_val(kind, n)};
  endfunction

  task automatic send_pixels(input int kind, input int count);
    logic [8:0] v;
    for (int i = 0; i < count; i++) begin
      v          = pix_val(kind, i);
      vif.ri     = v[8:6];
      vif.gi     = v[5:3];
      vif.bi     = v[2:0];
      vif.pix_ce = 1'b1;
      tick();
      vif.pix_ce = 1'b0;
      tick();
    end
    vif.ri = 3'd0;
    vif.gi = 3'd0;
    vif.bi = 3'd0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    n_total++;
    if ({vif.r, vif.g, vif.b, vif.hsync, vif.vsync, vif.csync} !== 12'b000_000_000_001) begin
      $display("FAIL reset_values got=%b required=%b",
               {vif.r, vif.g, vif.b, vif.hsync, vif.vsync, vif.csync}, 12'b000_000_000_001);
    end else n_pass++;
    rst = 1'b0;
  endtask

  task automatic test_passthrough();
    vif.ri = 3'd5; vif.gi = 3'd2; vif.bi = 3'd7; vif.pix_ce = 1'b1;
    tick();
    n_total++;
    if ({vif.r, vif.g, vif.b, vif.hsync, vif.csync} !== {3'd5, 3'd2, 3'd7, 1'b0, 1'b1}) begin
      $display("FAIL pass_rgb got=%b required=%b", {vif.r, vif.g, vif.b, vif.hsync, vif.csync},
               {3'd5, 3'd2, 3'd7, 1'b0, 1'b1});
    end else n_pass++;
    vif.pix_ce = 1'b0; vif.hsync_in = 1'b1;
    tick();
    n_total++;
    if ({vif.hsync, vif.csync, vif.r} !== {1'b1, 1'b0, 3'd5}) begin
      $display("FAIL pass_hsync got=%b required=%b", {vif.hsync, vif.csync, vif.r}, {1'b1, 1'b0, 3'd5});
    end else n_pass++;
    vif.hsync_in = 1'b0; vif.vsync_in = 1'b1;
    tick();
    n_total++;
    if ({vif.hsync, vif.vsync, vif.csync} !== 3'b010) begin
      $display("FAIL pass_vsync got=%b required=%b", {vif.hsync, vif.vsync, vif.csync}, 3'b010);
    end else n_pass++;
    vif.vsync_in = 1'b0;
    tick();
    n_total++;
    if ({vif.hsync, vif.vsync, vif.csync} !== 3'b001) begin
      $display("FAIL pass_sync_idle got=%b required=%b", {vif.hsync, vif.vsync, vif.csync}, 3'b001);
    end else n_pass++;
    // Enabling VGA mid-line keeps passthrough until the next line start
    vif.vga_en = 1'b1; vif.ri = 3'd3; vif.gi = 3'd3; vif.bi = 3'd3;
    tick();
    n_total++;
    if ({vif.r, vif.g, vif.b} !== 9'o333) begin
      $display("FAIL mode_0to1_wait got=%o required=%o", {vif.r, vif.g, vif.b}, 9'o333);
    end else n_pass++;
    vif.ri = 3'd0; vif.gi = 3'd0; vif.bi = 3'd0;
    tick();
  endtask

  task automatic test_len_zero();
    vif.hsync_in = 1'b1;
    for (int t = 1; t <= 8; t++) begin
      tick();
      if (t == 4) vif.hsync_in = 1'b0;
      n_total++;
      if (t == 1) begin
        if (vif.hsync !== 1'b1) $display("FAIL len0_pre_switch t=%0d got=%b required=1", t, vif.hsync);
        else n_pass++;
      end else if ({vif.hsync, vif.r, vif.g, vif.b} !== 10'd0) begin
        $display("FAIL len0_blank t=%0d got=%h required=000", t, {vif.hsync, vif.r, vif.g, vif.b});
      end else n_pass++;
    end
  endtask

  task automatic test_doubling();
    logic [9:0] e;
    send_pixels(0, 320);
    vif.hsync_in = 1'b1;
    for (int t = 1; t <= 650; t++) begin
      tick();
      if (t == 4) vif.hsync_in = 1'b0;
      e = exp_vga(t - 4, 320, 0);
      n_total++;
      if ({vif.vsync, vif.csync, vif.hsync, vif.r, vif.g, vif.b} !== {1'b0, ~e[9], e}) begin
        $display("FAIL doubling t=%0d got=%h required=%h", t,
                 {vif.vsync, vif.csync, vif.hsync, vif.r, vif.g, vif.b}, {1'b0, ~e[9], e});
      end else n_pass++;
    end
  endtask

  task automatic test_overflow();
    logic [9:0] e;
    send_pixels(1, 600);
    vif.hsync_in = 1'b1;
    for (int t = 1; t <= 1034; t++) begin
      tick();
      if (t == 4) vif.hsync_in = 1'b0;
      e = exp_vga(t - 4, 512, 1);
      n_total++;
      if ({vif.csync, vif.hsync, vif.r, vif.g, vif.b} !== {~e[9], e}) begin
        $display("FAIL overflow t=%0d got=%h required=%h", t,
                 {vif.csync, vif.hsync, vif.r, vif.g, vif.b}, {~e[9], e});
      end else n_pass++;
    end
  endtask

  task automatic test_abort();
    logic [9:0] e;
    logic [8:0] v;
    send_pixels(0, 200);
    vif.hsync_in = 1'b1;
    for (int t = 1; t <= 592; t++) begin
      tick();
      // Old line through PASS1 rx=100, then the new line follows with no gap
      e = (t <= 304) ? exp_vga(t - 4, 200, 0) : exp_vga(t - 305, 140, 2);
      n_total++;
      if ({vif.csync, vif.hsync, vif.r, vif.g, vif.b} !== {~e[9], e}) begin
        $display("FAIL abort t=%0d got=%h required=%h", t,
                 {vif.csync, vif.hsync, vif.r, vif.g, vif.b}, {~e[9], e});
      end else n_pass++;
      if (t == 4 || t == 305) vif.hsync_in = 1'b0;
      if (t == 301) vif.hsync_in = 1'b1;
      if (t >= 6 && t < 6 + 2 * 140 && ((t - 6) % 2) == 0) begin
        v = pix_val(2, (t - 6) / 2);
        vif.ri = v[8:6]; vif.gi = v[5:3]; vif.bi = v[2:0];
        vif.pix_ce = 1'b1;
      end else begin
        vif.pix_ce = 1'b0;
      end
    end
    vif.ri = 3'd0; vif.gi = 3'd0; vif.bi = 3'd0;
  endtask

  task automatic test_vsync();
    logic [9:0] e;
    logic       vs;
    for (int ln = 0; ln < 3; ln++) begin
      vif.vsync_in = (ln == 0);
      send_pixels(0, 20);
      vif.hsync_in = 1'b1;
      for (int t = 1; t <= 60; t++) begin
        tick();
        if (t == 4) vif.hsync_in = 1'b0;
        e  = exp_vga(t - 4, 20, 0);
        vs = (t >= 2) ? (ln == 1) : (ln == 2);
        n_total++;
        if ({vif.vsync, vif.csync} !== {vs, ~(vs | e[9])}) begin
          $display("FAIL vsync_latency line=%0d t=%0d got=%b required=%b", ln, t,
                   {vif.vsync, vif.csync}, {vs, ~(vs | e[9])});
        end else n_pass++;
      end
    end
    vif.vsync_in = 1'b0;
  endtask

  task automatic test_mode_switch();
    send_pixels(0, 100);
    vif.hsync_in = 1'b1;
    for (int t = 1; t <= 60; t++) begin
      tick();
      if (t == 4) vif.hsync_in = 1'b0;
    end
    vif.vga_en = 1'b0; vif.ri = 3'd6; vif.gi = 3'd1; vif.bi = 3'd4;
    tick();
    n_total++;
    if ({vif.hsync, vif.r, vif.g, vif.b, vif.csync} !== {1'b0, 9'o614, 1'b1}) begin
      $display("FAIL mode_1to0 got=%b required=%b", {vif.hsync, vif.r, vif.g, vif.b, vif.csync},
               {1'b0, 9'o614, 1'b1});
    end else n_pass++;
    vif.vga_en = 1'b1;
    tick();
    n_total++;
    if ({vif.r, vif.g, vif.b} !== 9'o614) begin
      $display("FAIL mode_reenable_wait got=%o required=%o", {vif.r, vif.g, vif.b}, 9'o614);
    end else n_pass++;
    vif.ri = 3'd0; vif.gi = 3'd0; vif.bi = 3'd0;
    tick();
  endtask

  task automatic test_reset_mid();
    logic [9:0] e;
    send_pixels(0, 64);
    vif.hsync_in = 1'b1;
    for (int t = 1; t <= 120; t++) begin
      tick();
      if (t == 4) vif.hsync_in = 1'b0;
    end
    e = exp_vga(116, 64, 0);
    n_total++;
    if ({vif.hsync, vif.r, vif.g, vif.b} !== e) begin
      $display("FAIL reset_mid_prepass got=%h required=%h", {vif.hsync, vif.r, vif.g, vif.b}, e);
    end else n_pass++;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_total++;
      if ({vif.r, vif.g, vif.b, vif.hsync, vif.vsync, vif.csync} !== 12'b000_000_000_001) begin
        $display("FAIL reset_mid cyc=%0d got=%b required=%b", i,
                 {vif.r, vif.g, vif.b, vif.hsync, vif.vsync, vif.csync}, 12'b000_000_000_001);
      end else n_pass++;
    end
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_total++;
      if ({vif.r, vif.g, vif.b, vif.hsync, vif.csync} !== 11'b000_000_000_01) begin
        $display("FAIL post_reset_idle cyc=%0d got=%b required=%b", i,
                 {vif.r, vif.g, vif.b, vif.hsync, vif.csync}, 11'b000_000_000_01);
      end else n_pass++;
    end
  endtask

  initial begin
    rst          = 1'b1;
    vif.vga_en   = 1'b0;
    vif.pix_ce   = 1'b0;
    vif.ri       = 3'd0;
    vif.gi       = 3'd0;
    vif.bi       = 3'd0;
    vif.hsync_in = 1'b0;
    vif.vsync_in = 1'b0;
    test_reset();
    test_passthrough();
    test_len_zero();
    test_doubling();
    test_overflow();
    test_abort();
    test_vsync();
    test_mode_switch();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
